voice_alloc: RTL
================

VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter VOICES, default 4: number of voice slots; SHALL be 2..8.
REQ-002 Parameter AGE_W, default 4: width of each per-voice age counter.
REQ-003 Port clk, input, 1: clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port note_on, input, 1: one-cycle note-on strobe.
REQ-006 Port note_off, input, 1: one-cycle note-off strobe.
REQ-007 Port note, input, 7: MIDI note number, qualified by note_on or note_off.
REQ-008 Port ev_ready, output, 1: high when an event can be accepted.
REQ-009 Port ev_drop, output, 1: one-cycle pulse when a strobe is discarded.
REQ-010 Port voice_note, output, 7*VOICES: voice i occupies bits [7i+6:7i].
REQ-011 Port voice_gate, output, VOICES: per-voice gate.
REQ-012 Port voice_trig, output, VOICES: one-cycle pulse on (re)assignment.
REQ-013 Port voice_steal, output, 1: one-cycle pulse when assignment took a gated voice with a different note.
REQ-014 Port any_gate, output, 1: OR of voice_gate.

Function
REQ-015 FSM states SHALL be IDLE, SCAN and APPLY; ev_ready SHALL be 1 only in IDLE.
REQ-016 Accept: in IDLE, a note_on or note_off strobe SHALL latch note and event type, set scan index to 0 and go to SCAN.
REQ-017 SCAN SHALL examine one voice per cycle, index 0..VOICES-1, then go to APPLY; APPLY SHALL last 1 cycle, then return to IDLE.
REQ-018 Latency: outputs SHALL change on edge VOICES+1 after the accept edge (edge 5 for defaults), and ev_ready SHALL be high from that edge.
REQ-019 note_on and note_off in the same IDLE cycle: note_on SHALL be accepted, note_off discarded, and ev_drop pulsed.
REQ-020 Any strobe while not IDLE SHALL be discarded with an ev_drop pulse on the next edge; it has no other effect.
REQ-021 note_on target selection, in order: (a) the lowest-index gated voice holding the same note (retrigger); (b) the lowest-index ungated voice; (c) the gated voice with the largest age, ties broken by lowest index (steal).
REQ-022 note_on APPLY: target note set to the latched note, gate set to 1, age set to 0, trig bit pulsed for 1 cycle; voice_steal pulsed only in case (c).
REQ-023 note_on APPLY: every non-target voice age SHALL increment by 1, saturating at 2^AGE_W-1.
REQ-024 note_off APPLY: every gated voice with a matching note SHALL have its gate cleared; note and age are unchanged; no trig pulse.
REQ-025 note_off with no matching gated voice SHALL change nothing and SHALL NOT pulse ev_drop.
REQ-026 voice_note SHALL hold its value after the gate clears, so release phases keep pitch.
REQ-027 voice_trig, voice_steal and ev_drop SHALL be registered pulses exactly 1 cycle wide; no more than one voice_trig bit may be high at a time.
REQ-028 any_gate SHALL be combinational from the registered voice_gate.

Reset
REQ-029 When rst is sampled high: FSM to IDLE, ev_ready=1, all voice_note=0, voice_gate=0, ages=0, voice_trig=0, voice_steal=0, ev_drop=0, any_gate=0.
REQ-030 rst during SCAN or APPLY SHALL abort the event with no output update and no pulse.
REQ-031 Strobes in the same cycle as rst SHALL be ignored, with no ev_drop.

Verification (defaults VOICES=4, AGE_W=4)
REQ-032 After reset, note_on 60 -> 5 edges later: voice0 note=60, gate=0001, trig=0001 for 1 cycle, ev_ready high again.
REQ-033 note_on 60, 62, 64, 65, then 67 (each after ev_ready) -> 67 steals voice0 (age 3, oldest); voice_steal pulses; gate=1111.
REQ-034 Voices hold 60/62, then note_on 62 again -> voice1 retriggered, trig=0010, no steal, voice0 age increments.
REQ-035 note_off 62 with voice1=62 -> gate bit1 clears, voice_note[13:7] stays 62; then note_off 70 -> no change, no ev_drop.
REQ-036 note_on 60 accepted, note_on 61 two cycles later -> ev_drop pulse, only 60 assigned; simultaneous note_on 50 and note_off 50 in IDLE -> 50 assigned, ev_drop pulse.
REQ-037 rst asserted 2 cycles after accepting note_on 60 -> all outputs at reset values, no trig, ev_ready=1 the cycle after.

Source files
------------

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: one note event is accepted at a time, the voice
// table is scanned one slot per cycle, then the chosen voice is updated.
module voice_alloc #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned AGE_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  note_on,
  input  logic                  note_off,
  input  logic [6:0]            note,
  output logic                  ev_ready,
  output logic                  ev_drop,
  output logic [7*VOICES-1:0]   voice_note,
  output logic [VOICES-1:0]     voice_gate,
  output logic [VOICES-1:0]     voice_trig,
  output logic                  voice_steal,
  output logic                  any_gate
);

  localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             ev_on;
  logic [6:0]       ev_note;
  logic [AGE_W-1:0] age [VOICES];

  logic             same_hit, free_hit, old_hit;
  logic [IDX_W-1:0] same_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;

  logic [6:0]       scan_note;
  logic             scan_gate;
  logic [AGE_W-1:0] scan_age;
  logic [IDX_W-1:0] tgt;
  logic             do_steal;
  logic             strobe;

  assign strobe   = note_on | note_off;
  assign ev_ready = (state == IDLE);
  assign any_gate = |voice_gate;

  always_comb begin
    scan_note = '0;
    scan_gate = 1'b0;
    scan_age  = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      if (idx == IDX_W'(i)) begin
        scan_note = voice_note[i*7 +: 7];
        scan_gate = voice_gate[i];
        scan_age  = age[i];
      end
    end
  end

  // Priority: retrigger same note, else first free voice, else steal oldest.
  always_comb begin
    do_steal = !same_hit && !free_hit;
    if (same_hit)
      tgt = same_idx;
    else if (free_hit)
      tgt = free_idx;
    else
      tgt = old_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      ev_on       <= 1'b0;
      ev_note     <= '0;
      voice_note  <= '0;
      voice_gate  <= '0;
      voice_trig  <= '0;
      voice_steal <= 1'b0;
      ev_drop     <= 1'b0;
      same_hit    <= 1'b0;
      free_hit    <= 1'b0;
      old_hit     <= 1'b0;
      same_idx    <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      for (int unsigned i = 0; i < VOICES; i++)
        age[i] <= '0;
    end else begin
      voice_trig  <= '0;
      voice_steal <= 1'b0;
      ev_drop     <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            ev_on    <= note_on;
            ev_note  <= note;
            idx      <= '0;
            same_hit <= 1'b0;
            free_hit <= 1'b0;
            old_hit  <= 1'b0;
            ev_drop  <= note_on && note_off;
            state    <= SCAN;
          end
        end
        SCAN: begin
          ev_drop <= strobe;
          if (scan_gate && scan_note == ev_note && !same_hit) begin
            same_hit <= 1'b1;
            same_idx <= idx;
          end
          if (!scan_gate && !free_hit) begin
            free_hit <= 1'b1;
            free_idx <= idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (scan_gate && (!old_hit || scan_age > old_age)) begin
            old_hit <= 1'b1;
            old_idx <= idx;
            old_age <= scan_age;
          end
          if (idx == IDX_W'(VOICES - 1))
            state <= APPLY;
          else
            idx <= idx + 1'b1;
        end
        APPLY: begin
          ev_drop <= strobe;
          state   <= IDLE;
          if (ev_on) begin
            voice_steal <= do_steal;
            for (int unsigned i = 0; i < VOICES; i++) begin
              if (IDX_W'(i) == tgt) begin
                voice_note[i*7 +: 7] <= ev_note;
                voice_gate[i]        <= 1'b1;
                voice_trig[i]        <= 1'b1;
                age[i]               <= '0;
              end else if (age[i] != '1) begin
                age[i] <= age[i] + 1'b1;
              end
            end
          end else begin
            for (int unsigned i = 0; i < VOICES; i++) begin
              if (voice_gate[i] && voice_note[i*7 +: 7] == ev_note)
                voice_gate[i] <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
